// File: rtl/decode_stage_pkg.sv
// Shared execute-side types: opcodes, operation enums and the decoded packet.
package decode_stage_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {INST_REG_IMM, INST_REG_REG, INST_PC_IMM} e_inst_type;

  typedef enum logic [4:0] {
    ALU_DISABLE, ALU_ADD, ALU_ADD_SIGN_FLIP, ALU_SUB, ALU_SLL, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } e_alu_function;

  // Encoded as branch funct3 so branches can cast directly; 010 is never a legal branch.
  typedef enum logic [2:0] {
    CMP_EQ = 3'b000, CMP_NE = 3'b001, CMP_DISABLE = 3'b010,
    CMP_LT = 3'b100, CMP_GE = 3'b101, CMP_LTU = 3'b110, CMP_GEU = 3'b111
  } e_cmp_function;

  typedef enum logic [1:0] {SOURCE_ALU, SOURCE_CMP, SOURCE_SEQ_PC} e_rf_write_source;

  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} e_occupancy;

  typedef struct packed {
    e_inst_type       inst_type;
    e_alu_function    alu_function;
    e_cmp_function    cmp_function;
    e_rf_write_source rf_write_source;
    logic [4:0]       reg1;
    logic [4:0]       reg2;
    logic [4:0]       rd;
    logic             is_linking_branch;
    logic             illegal;
  } decoded_inst_t;

  localparam decoded_inst_t DEC_DEFAULT = '{
    inst_type: INST_REG_IMM, alu_function: ALU_DISABLE, cmp_function: CMP_DISABLE,
    rf_write_source: SOURCE_CMP, reg1: 5'd0, reg2: 5'd0, rd: 5'd0,
    is_linking_branch: 1'b0, illegal: 1'b0};

  // Shared OP/OP-IMM mapping; SLT/SLTU are handled by the caller as compares.
  function automatic e_alu_function alu_of(logic [2:0] f3, logic alt);
    e_alu_function a;
    a = ALU_DISABLE;
    case (f3)
      3'b000: a = alt ? ALU_SUB : ALU_ADD;
      3'b001: a = ALU_SLL;
      3'b100: a = ALU_XOR;
      3'b101: a = alt ? ALU_SRA : ALU_SRL;
      3'b110: a = ALU_OR;
      3'b111: a = ALU_AND;
      default: a = ALU_DISABLE;
    endcase
    return a;
  endfunction

  function automatic e_alu_function mul_of(logic [2:0] f3);
    e_alu_function a;
    a = ALU_MUL;
    case (f3)
      3'b000: a = ALU_MUL;
      3'b001: a = ALU_MULH;
      3'b010: a = ALU_MULHSU;
      3'b011: a = ALU_MULHU;
      3'b100: a = ALU_DIV;
      3'b101: a = ALU_DIVU;
      3'b110: a = ALU_REM;
      default: a = ALU_REMU;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I(+M) decoder: instruction word to decoded bundle plus XLEN immediate.
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0
) (
  input  logic [31:0]     inst,
  output decoded_inst_t   dec,
  output logic [XLEN-1:0] imm
);
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  logic [XLEN-1:0] imm_i, imm_u, imm_b, imm_j;
  logic ok;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  always_comb begin
    dec    = DEC_DEFAULT;
    dec.rd = rd;
    imm    = '0;
    ok     = 1'b1;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        dec.inst_type       = (opcode == OP_LUI) ? INST_REG_IMM : INST_PC_IMM;
        dec.alu_function    = ALU_ADD;
        dec.rf_write_source = SOURCE_ALU;
        imm                 = imm_u;
      end
      OP_JAL: begin
        dec.inst_type         = INST_PC_IMM;
        dec.alu_function      = ALU_ADD_SIGN_FLIP;
        dec.rf_write_source   = SOURCE_SEQ_PC;
        dec.is_linking_branch = 1'b1;
        imm                   = imm_j;
      end
      OP_JALR: begin
        ok                    = (funct3 == 3'b000);
        dec.alu_function      = ALU_ADD_SIGN_FLIP;
        dec.rf_write_source   = SOURCE_SEQ_PC;
        dec.is_linking_branch = 1'b1;
        dec.reg1              = rs1;
        imm                   = imm_i;
      end
      OP_BRANCH: begin
        ok               = (funct3[2:1] != 2'b01);
        dec.inst_type    = INST_PC_IMM;
        dec.alu_function = ALU_ADD_SIGN_FLIP;
        dec.cmp_function = e_cmp_function'(funct3);
        dec.reg1         = rs1;
        dec.reg2         = rs2;
        dec.rd           = 5'd0;
        imm              = imm_b;
      end
      OP_IMM: begin
        dec.reg1            = rs1;
        dec.rf_write_source = SOURCE_ALU;
        imm                 = imm_i;
        case (funct3)
          3'b010, 3'b011: begin
            dec.cmp_function    = funct3[0] ? CMP_LTU : CMP_LT;
            dec.rf_write_source = SOURCE_CMP;
          end
          3'b001: begin
            ok               = (funct7 == 7'b0000000);
            dec.alu_function = ALU_SLL;
          end
          3'b101: begin
            ok               = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            dec.alu_function = alu_of(funct3, funct7[5]);
          end
          default: dec.alu_function = alu_of(funct3, 1'b0);
        endcase
      end
      OP_REG: begin
        dec.inst_type       = INST_REG_REG;
        dec.reg1            = rs1;
        dec.reg2            = rs2;
        dec.rf_write_source = SOURCE_ALU;
        if (funct7 == 7'b0000001) begin
          ok               = (ENABLE_M != 0);
          dec.alu_function = mul_of(funct3);
        end else if (funct7 == 7'b0000000 ||
                     (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          if (funct3[2:1] == 2'b01) begin
            dec.cmp_function    = funct3[0] ? CMP_LTU : CMP_LT;
            dec.rf_write_source = SOURCE_CMP;
          end else begin
            dec.alu_function = alu_of(funct3, funct7[5]);
          end
        end else begin
          ok = 1'b0;
        end
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      dec         = DEC_DEFAULT;
      dec.illegal = 1'b1;
      imm         = '0;
    end
  end
endmodule

// File: rtl/decode_stage.sv
// Flow-controlled decode stage: output register plus one skid entry, registered fetch_ready.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [XLEN-1:0]  fetch_pc,
  input  logic [XLEN-1:0]  fetch_pred_next_pc,
  input  logic [31:0]      fetch_inst,
  input  logic             flush,
  output logic             exec_valid,
  input  logic             exec_ready,
  output logic [XLEN-1:0]  exec_pc,
  output logic [XLEN-1:0]  exec_pred_next_pc,
  output logic [XLEN-1:0]  exec_imm,
  output e_inst_type       exec_inst_type,
  output e_alu_function    exec_alu_function,
  output e_cmp_function    exec_cmp_function,
  output e_rf_write_source exec_rf_write_source,
  output logic [4:0]       exec_reg1,
  output logic [4:0]       exec_reg2,
  output logic [4:0]       exec_rd,
  output logic             exec_is_linking_branch,
  output logic             exec_illegal
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pred_next_pc;
    logic [XLEN-1:0] imm;
    decoded_inst_t   dec;
  } pkt_t;

  e_occupancy state, state_nx;
  pkt_t in_pkt, out_q, skid_q;
  decoded_inst_t in_dec;
  logic [XLEN-1:0] in_imm;
  logic ready_q, accept, consume, load_out, load_skid, from_skid;

  decode_comb #(.XLEN(XLEN), .ENABLE_M(ENABLE_M)) u_dec (
    .inst (fetch_inst),
    .dec  (in_dec),
    .imm  (in_imm)
  );

  assign in_pkt  = '{pc: fetch_pc, pred_next_pc: fetch_pred_next_pc, imm: in_imm, dec: in_dec};
  assign accept  = fetch_valid && ready_q && !flush;
  assign consume = exec_valid && exec_ready;

  always_comb begin
    state_nx  = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    if (flush) begin
      state_nx = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: if (accept) begin
          state_nx = OCC_ONE;
          load_out = 1'b1;
        end
        OCC_ONE: if (accept && !consume) begin
          state_nx  = OCC_TWO;
          load_skid = 1'b1;
        end else if (accept) begin
          load_out = 1'b1;
        end else if (consume) begin
          state_nx = OCC_EMPTY;
        end
        OCC_TWO: if (consume) begin
          state_nx  = OCC_ONE;
          load_out  = 1'b1;
          from_skid = 1'b1;
        end
        default: state_nx = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= OCC_EMPTY;
      ready_q    <= 1'b1;
      out_q      <= '0;
      out_q.dec  <= DEC_DEFAULT;
      skid_q     <= '0;
    end else begin
      state   <= state_nx;
      ready_q <= (state_nx != OCC_TWO);
      if (load_out)  out_q  <= from_skid ? skid_q : in_pkt;
      if (load_skid) skid_q <= in_pkt;
    end
  end

  assign fetch_ready            = ready_q;
  assign exec_valid             = (state != OCC_EMPTY);
  assign exec_pc                = out_q.pc;
  assign exec_pred_next_pc      = out_q.pred_next_pc;
  assign exec_imm               = out_q.imm;
  assign exec_inst_type         = out_q.dec.inst_type;
  assign exec_alu_function      = out_q.dec.alu_function;
  assign exec_cmp_function      = out_q.dec.cmp_function;
  assign exec_rf_write_source   = out_q.dec.rf_write_source;
  assign exec_reg1              = out_q.dec.reg1;
  assign exec_reg2              = out_q.dec.reg2;
  assign exec_rd                = out_q.dec.rd;
  assign exec_is_linking_branch = out_q.dec.is_linking_branch;
  assign exec_illegal           = out_q.dec.illegal;
endmodule
